gpu_line_raster: RTL
====================

Name: gpu_line_raster

Overview:
- Parametrised successor to the GPU Bresenham line drawer.
- Accepts two endpoints, steps through all eight octants, and emits one pixel coordinate per accepted transfer on a valid/ready stream, so downstream (framebuffer writer / arbiter) may stall it.
- Sits between the GPU command decoder and the framebuffer write path.
- Reports busy, a one-cycle done pulse, and the pixel count of the last line.

Parameters:
- W_BITS, 10, x coordinate width (unsigned)
- H_BITS, 9, y coordinate width (unsigned)
- SCREEN_W, 640, visible width; used only when clipping is compiled in
- SCREEN_H, 480, visible height; used only when clipping is compiled in

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a line; sampled only in IDLE
- x0  in  W_BITS  start x
- y0  in  H_BITS  start y
- x1  in  W_BITS  end x
- y1  in  H_BITS  end y
- pix_valid  out  1  X/Y hold a pixel to write
- pix_ready  in  1  downstream accepts the pixel this cycle
- X  out  W_BITS  pixel x
- Y  out  H_BITS  pixel y
- busy  out  1  high in DRAW and DONE states
- done  out  1  one-cycle pulse after the final pixel has been handled
- pix_count  out  W_BITS+1  number of pixels stepped for the last line; holds its value until the next start

Behaviour:
- Reset (async, rst=1): state=IDLE; pix_valid=0, busy=0, done=0, X=0, Y=0, pix_count=0. Asserting rst mid-line aborts immediately, with no done pulse.
- Arithmetic: E_BITS = max(W_BITS,H_BITS)+2, signed.
  - dx=|x1-x0|, dy=-|y1-y0|
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
  - err=dx+dy
- State IDLE: on start=1, latch endpoints, compute dx/dy/sx/sy/err, set X=x0, Y=y0, pix_count=0, go to DRAW. First pix_valid is high the next cycle (latency 1).
- State DRAW: pix_valid=1.
  - On pix_valid&&pix_ready: pix_count+=1.
  - If X==x1 and Y==y1, go to DONE.
  - Otherwise, with e2=2*err:
    - if e2>=dy: x steps by sx and err gains dy;
    - if e2<=dx: y steps by sy and err gains dx;
    - both conditions use the pre-update err, and both increments are applied in the same cycle when both hold.
  - If pix_ready=0: X, Y and pix_valid hold stable; no state advances.
- State DONE: pix_valid=0, done=1 for exactly one cycle, then go to IDLE. busy drops in the same cycle the FSM enters IDLE.
- start while busy: ignored; latched endpoints are unaffected. Endpoint input changes during DRAW have no effect.
- Degenerate line x0==x1, y0==y1: exactly one pixel, then done.
- Throughput: one pixel per cycle with pix_ready held high. Total cycles from start to done = N+2, where N = max(|dx|,|dy|)+1.
- Endpoints at 0 or at full-scale coordinate values must not wrap; the signed E_BITS width guarantees this.

Optional Feature:
- Macro: GPU_LINE_CLIP_EN.
- Defined:
  - The FSM still steps every Bresenham point.
  - Points with X>=SCREEN_W or Y>=SCREEN_H are not presented. pix_valid=0 for that cycle, and the point advances without waiting for pix_ready.
  - pix_count counts only emitted pixels.
  - A fully off-screen line still produces done.
- Undefined:
  - Every point is emitted.
  - SCREEN_W and SCREEN_H are unused.

Test Plan:
1. (0,0)->(9,9), pix_ready=1 -> pixels (0,0),(1,1)…(9,9) on consecutive cycles; done 11 cycles after start; pix_count=10.
2. (8,8)->(0,0), preceded by a mid-line rst assertion on test 1 -> pix_valid, busy and done drop to 0 immediately on rst; then (8,8),(7,7)…(0,0), 9 pixels; done pulses once.
3. (0,0)->(4,1) -> exactly (0,0),(1,0),(2,1),(3,1),(4,1); (4,1)->(0,0) gives the mirrored sequence.
4. Backpressure on (0,0)->(9,9): pix_ready toggled 1,0,0,1… -> X/Y stable while stalled; no pixel lost or duplicated; still 10 pixels; pix_count=10.
5. (3,5)->(3,5), plus start re-asserted during busy on a long line -> single pixel (3,5) then done; the re-start has no effect on the line in progress.
6. GPU_LINE_CLIP_EN with SCREEN_W=8: (5,0)->(10,0) -> only (5,0),(6,0),(7,0) emitted; pix_count=3; done asserted after all 6 points are stepped.

Source files
------------

// File: rtl/gpu_line_raster_if.sv
// Command and pixel-stream bundle for the Bresenham line rasteriser.
// The command decoder and pixel consumer use master; the rasteriser uses slave.
interface gpu_line_raster_if #(
  parameter int W_BITS = 10,
  parameter int H_BITS = 9
);
  logic              start;
  logic [W_BITS-1:0] x0;
  logic [H_BITS-1:0] y0;
  logic [W_BITS-1:0] x1;
  logic [H_BITS-1:0] y1;
  logic              pix_valid;
  logic              pix_ready;
  logic [W_BITS-1:0] X;
  logic [H_BITS-1:0] Y;

  modport master (
    output start, x0, y0, x1, y1, pix_ready,
    input  pix_valid, X, Y
  );

  modport slave (
    input  start, x0, y0, x1, y1, pix_ready,
    output pix_valid, X, Y
  );
endinterface

// File: rtl/gpu_line_raster.sv
// Bresenham line rasteriser, all eight octants, one pixel per accepted beat.
// Define GPU_LINE_CLIP_EN to suppress points outside SCREEN_W x SCREEN_H.
module gpu_line_raster #(
  parameter int W_BITS   = 10,
  parameter int H_BITS   = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic              clk,
  input  logic              rst,
  gpu_line_raster_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic [W_BITS:0]   pix_count
);

  localparam int MAX_B  = (W_BITS > H_BITS) ? W_BITS : H_BITS;
  localparam int E_BITS = MAX_B + 2;

`ifdef GPU_LINE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef logic signed [E_BITS-1:0] err_t;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  function automatic err_t abs_e(input err_t v);
    return (v < 0) ? -v : v;
  endfunction

  state_t            r_state, w_next;
  logic [W_BITS-1:0] r_x, r_x1;
  logic [H_BITS-1:0] r_y, r_y1;
  logic [W_BITS:0]   r_cnt;
  err_t              r_dx, r_dy, r_err;
  logic              r_sx, r_sy;

  err_t                 w_x0e, w_x1e, w_y0e, w_y1e, w_dx0, w_dy0, w_err_nxt;
  logic signed [E_BITS:0] w_e2, w_dxw, w_dyw;
  logic                 w_stepx, w_stepy, w_last, w_vis, w_adv, w_load;

  // Zero-extend into the signed error domain so 0 and full-scale never wrap
  assign w_x0e = err_t'({{(E_BITS-W_BITS){1'b0}}, bus.x0});
  assign w_x1e = err_t'({{(E_BITS-W_BITS){1'b0}}, bus.x1});
  assign w_y0e = err_t'({{(E_BITS-H_BITS){1'b0}}, bus.y0});
  assign w_y1e = err_t'({{(E_BITS-H_BITS){1'b0}}, bus.y1});
  assign w_dx0 = abs_e(w_x1e - w_x0e);
  assign w_dy0 = -abs_e(w_y1e - w_y0e);

  assign w_e2      = {r_err, 1'b0};
  assign w_dxw     = {r_dx[E_BITS-1], r_dx};
  assign w_dyw     = {r_dy[E_BITS-1], r_dy};
  assign w_stepx   = (w_e2 >= w_dyw);
  assign w_stepy   = (w_e2 <= w_dxw);
  assign w_err_nxt = r_err + (w_stepx ? r_dy : '0) + (w_stepy ? r_dx : '0);
  assign w_last    = (r_x == r_x1) && (r_y == r_y1);

  // Off-screen points are stepped over without waiting on the consumer
  assign w_vis  = !CLIP_EN || ((int'(r_x) < SCREEN_W) && (int'(r_y) < SCREEN_H));
  assign w_adv  = (r_state == S_DRAW) && (bus.pix_ready || !w_vis);
  assign w_load = (r_state == S_IDLE) && bus.start;

  assign bus.pix_valid = (r_state == S_DRAW) && w_vis;
  assign bus.X         = r_x;
  assign bus.Y         = r_y;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign pix_count     = r_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_DRAW;
      S_DRAW:  if (w_adv && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_x   <= bus.x0;
        r_y   <= bus.y0;
        r_cnt <= '0;
      end else begin
        if (bus.pix_valid && bus.pix_ready) r_cnt <= r_cnt + 1'b1;
        if (w_adv && !w_last) begin
          if (w_stepx) r_x <= r_sx ? r_x + 1'b1 : r_x - 1'b1;
          if (w_stepy) r_y <= r_sy ? r_y + 1'b1 : r_y - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_x1  <= bus.x1;
      r_y1  <= bus.y1;
      r_dx  <= w_dx0;
      r_dy  <= w_dy0;
      r_err <= w_dx0 + w_dy0;
      r_sx  <= (bus.x0 < bus.x1);
      r_sy  <= (bus.y0 < bus.y1);
    end else if (w_adv && !w_last) begin
      r_err <= w_err_nxt;
    end
  end

endmodule
